// File: rtl/memory_unit_pkg.sv
// Shared LC-3 memory-map constants and address decode helper.
package lc3;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        RG_RAM,
        RG_KBSR,
        RG_KBDR,
        RG_DSR,
        RG_DDR,
        RG_NONE
    } region_e;

    // Classify an address into RAM, one of the MMIO registers, or unmapped.
    function automatic region_e decodeAddr(input logic [15:0] addr, input int unsigned ramWords);
        region_e r;
        if (32'(addr) < ramWords) begin
            r = RG_RAM;
        end else begin
            case (addr)
                ADDR_KBSR: r = RG_KBSR;
                ADDR_KBDR: r = RG_KBDR;
                ADDR_DSR:  r = RG_DSR;
                ADDR_DDR:  r = RG_DDR;
                default:   r = RG_NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/memory_unit_ram.sv
// Single-port RAM: synchronous write, combinational read (registered by the caller).
module memory_ram #(
    parameter int unsigned WORDS = 512,
    localparam int unsigned AW   = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_unit.sv
// LC-3 memory unit: MAR/MDR, RAM and keyboard/display MMIO registers.
module memory_unit
    import lc3::*;
#(
    parameter int unsigned RAM_WORDS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memWE,
    output logic [15:0] mdrOut,
    input  logic        kbdValid,
    input  logic [15:0] kbdData,
    output logic        kbdReady,
    output logic        dispValid,
    output logic [15:0] dispData,
    input  logic        dispReady,
    output logic        dispOverrun
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] kbdBuf;
    logic        kbdFull;
    logic [15:0] ramRdata;
    logic [15:0] readVal_c;
    region_e     marRegion_c;
    logic        ramWe_c;
    logic        kbdRead_c;
    logic        kbdCapture_c;
    logic        ddrWrite_c;
    logic        dispDone_c;

    assign marRegion_c  = decodeAddr(mar, RAM_WORDS);
    assign ramWe_c      = memWE && !reset && (marRegion_c == RG_RAM);
    assign kbdRead_c    = ldMDR && selMDR && (marRegion_c == RG_KBDR);
    assign kbdCapture_c = kbdValid && !kbdFull;
    assign ddrWrite_c   = memWE && (marRegion_c == RG_DDR);
    assign dispDone_c   = dispValid && dispReady;

    assign mdrOut   = mdr;
    assign kbdReady = !kbdFull;

    memory_ram #(.WORDS(RAM_WORDS)) u_ram (
        .clk   (clk),
        .we    (ramWe_c),
        .addr  (mar[AW-1:0]),
        .wdata (mdr),
        .rdata (ramRdata)
    );

    // Read-data mux at the current MAR; unmapped addresses read as zero.
    always_comb begin
        readVal_c = '0;
        case (marRegion_c)
            RG_RAM:  readVal_c = ramRdata;
            RG_KBSR: readVal_c = {kbdFull, 15'b0};
            RG_KBDR: readVal_c = kbdBuf;
            RG_DSR:  readVal_c = {!dispValid, 15'b0};
            default: readVal_c = '0;
        endcase
    end

    // MAR/MDR loads; all sources use pre-edge register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (ldMAR) mar <= bus;
            if (ldMDR) mdr <= selMDR ? readVal_c : bus;
        end
    end

    // Keyboard data register: capture only when empty, so a clearing read blocks capture that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbdFull <= 1'b0;
            kbdBuf  <= '0;
        end else if (kbdCapture_c) begin
            kbdFull <= 1'b1;
            kbdBuf  <= kbdData;
        end else if (kbdRead_c) begin
            kbdFull <= 1'b0;
        end
    end

    // Display data register with ready/valid handshake and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            dispValid   <= 1'b0;
            dispData    <= '0;
            dispOverrun <= 1'b0;
        end else begin
            if (ddrWrite_c && (!dispValid || dispDone_c)) begin
                dispValid <= 1'b1;
                dispData  <= mdr;
            end else if (dispDone_c) begin
                dispValid <= 1'b0;
            end
            if (ddrWrite_c && dispValid && !dispDone_c) begin
                dispOverrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit.
module tb_memory_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus;
    logic        ldMAR, ldMDR, selMDR, memWE;
    logic [15:0] mdrOut;
    logic        kbdValid;
    logic [15:0] kbdData;
    logic        kbdReady;
    logic        dispValid;
    logic [15:0] dispData;
    logic        dispReady;
    logic        dispOverrun;

    int checks = 0;
    int errors = 0;

    memory_unit #(.RAM_WORDS(512)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .ldMAR       (ldMAR),
        .ldMDR       (ldMDR),
        .selMDR      (selMDR),
        .memWE       (memWE),
        .mdrOut      (mdrOut),
        .kbdValid    (kbdValid),
        .kbdData     (kbdData),
        .kbdReady    (kbdReady),
        .dispValid   (dispValid),
        .dispData    (dispData),
        .dispReady   (dispReady),
        .dispOverrun (dispOverrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ldMAR  = 1'b0;
        ldMDR  = 1'b0;
        selMDR = 1'b0;
        memWE  = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setMar(input logic [15:0] a);
        idle(); bus = a; ldMAR = 1'b1; tick(); idle();
    endtask

    task automatic setMdr(input logic [15:0] d);
        idle(); bus = d; ldMDR = 1'b1; tick(); idle();
    endtask

    task automatic memWrite(input logic [15:0] a, input logic [15:0] d);
        setMar(a);
        setMdr(d);
        memWE = 1'b1; tick(); idle();
    endtask

    task automatic memRead(input logic [15:0] a);
        setMar(a);
        ldMDR = 1'b1; selMDR = 1'b1; tick(); idle();
    endtask

    initial begin
        idle();
        reset = 1'b1; bus = '0; kbdValid = 1'b0; kbdData = '0; dispReady = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_mdr", mdrOut, 16'h0000);
        chk("rst_kbdReady", 16'(kbdReady), 16'h0001);
        chk("rst_dispValid", 16'(dispValid), 16'h0000);
        chk("rst_dispOverrun", 16'(dispOverrun), 16'h0000);
        chk("rst_dispData", dispData, 16'h0000);

        // Basic write then read-back at 0x0010
        setMar(16'h0010);
        setMdr(16'hBEEF);
        chk("mdr_from_bus", mdrOut, 16'hBEEF);
        memWE = 1'b1; tick(); idle();
        setMdr(16'h0000);
        ldMDR = 1'b1; selMDR = 1'b1; tick(); idle();
        chk("read_0010", mdrOut, 16'hBEEF);

        // Simultaneous ldMAR/ldMDR/memWE use old MAR/MDR
        memWrite(16'h0020, 16'h2222);
        setMar(16'h0010);
        setMdr(16'h1111);
        bus = 16'h0020; ldMAR = 1'b1; ldMDR = 1'b1; memWE = 1'b1; tick(); idle();
        chk("simul_mdr", mdrOut, 16'h0020);
        memRead(16'h0010);
        chk("simul_mem10", mdrOut, 16'h1111);
        memRead(16'h0020);
        chk("simul_mem20", mdrOut, 16'h2222);

        // Read of an address written in the same cycle returns old data
        memWrite(16'h0030, 16'hAAAA);
        setMdr(16'h5555);
        memWE = 1'b1; ldMDR = 1'b1; selMDR = 1'b1; tick(); idle();
        chk("rdw_old", mdrOut, 16'hAAAA);
        ldMDR = 1'b1; selMDR = 1'b1; tick(); idle();
        chk("rdw_new", mdrOut, 16'h5555);

        // RAM boundary and unmapped space
        memWrite(16'h01FF, 16'h7777);
        memWrite(16'h0000, 16'h0C0C);
        memWrite(16'h0200, 16'hDEAD);
        memWrite(16'h1000, 16'h1234);
        memRead(16'h01FF);
        chk("ram_top", mdrOut, 16'h7777);
        memRead(16'h0000);
        chk("no_alias", mdrOut, 16'h0C0C);
        memRead(16'h0200);
        chk("unmapped_0200", mdrOut, 16'h0000);
        memRead(16'hFE08);
        chk("unmapped_fe08", mdrOut, 16'h0000);

        // Keyboard
        memRead(16'hFE00);
        chk("kbsr_empty", mdrOut, 16'h0000);
        kbdValid = 1'b1; kbdData = 16'h0041; tick(); kbdValid = 1'b0;
        chk("kbd_full", 16'(kbdReady), 16'h0000);
        memRead(16'hFE00);
        chk("kbsr_full", mdrOut, 16'h8000);
        kbdValid = 1'b1; kbdData = 16'h0042;
        setMar(16'hFE02);
        ldMDR = 1'b1; selMDR = 1'b1; tick(); idle();
        chk("kbdr_read", mdrOut, 16'h0041);
        chk("kbd_no_capture_on_clear", 16'(kbdReady), 16'h0001);
        tick(); kbdValid = 1'b0;
        chk("kbd_capture2", 16'(kbdReady), 16'h0000);
        memRead(16'hFE02);
        chk("kbdr_read2", mdrOut, 16'h0042);
        memWrite(16'hFE00, 16'hFFFF);
        memRead(16'hFE00);
        chk("kbsr_write_ignored", mdrOut, 16'h0000);

        // Display
        memRead(16'hFE04);
        chk("dsr_idle", mdrOut, 16'h8000);
        memWrite(16'hFE06, 16'h0048);
        chk("ddr_valid", 16'(dispValid), 16'h0001);
        chk("ddr_data", dispData, 16'h0048);
        memRead(16'hFE04);
        chk("dsr_busy", mdrOut, 16'h0000);
        memWrite(16'hFE06, 16'h0049);
        chk("ddr_drop_data", dispData, 16'h0048);
        chk("ddr_overrun", 16'(dispOverrun), 16'h0001);
        dispReady = 1'b1; tick(); dispReady = 1'b0;
        chk("ddr_done", 16'(dispValid), 16'h0000);

        // DDR write coinciding with a completing transfer
        memWrite(16'hFE06, 16'h0050);
        setMdr(16'h0051);
        memWE = 1'b1; dispReady = 1'b1; tick(); idle(); dispReady = 1'b0;
        chk("ddr_b2b_valid", 16'(dispValid), 16'h0001);
        chk("ddr_b2b_data", dispData, 16'h0051);
        dispReady = 1'b1; tick(); dispReady = 1'b0;
        chk("ddr_b2b_done", 16'(dispValid), 16'h0000);
        chk("overrun_sticky", 16'(dispOverrun), 16'h0001);

        // Reset with pending display character and full keyboard
        memWrite(16'hFE06, 16'h0060);
        kbdValid = 1'b1; kbdData = 16'h0077; tick(); kbdValid = 1'b0;
        chk("pre_rst_kbd", 16'(kbdReady), 16'h0000);
        reset = 1'b1; bus = 16'hFFFF; ldMDR = 1'b1; dispReady = 1'b0; tick(); idle(); reset = 1'b0;
        chk("rst2_dispValid", 16'(dispValid), 16'h0000);
        chk("rst2_kbdReady", 16'(kbdReady), 16'h0001);
        chk("rst2_mdr", mdrOut, 16'h0000);
        chk("rst2_overrun", 16'(dispOverrun), 16'h0000);
        chk("rst2_dispData", dispData, 16'h0000);
        memRead(16'h0010);
        chk("ram_kept_0010", mdrOut, 16'h1111);
        memRead(16'h01FF);
        chk("ram_kept_01ff", mdrOut, 16'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 512, giving the RAM depth in 16-bit words, mapped at 0x0000..RAM_WORDS-1.
REQ-002 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port bus, input, 16: datapath bus value, the source for MAR and MDR loads.
REQ-005 Port ldMAR, input, 1: MAR <= bus.
REQ-006 Port ldMDR, input, 1: load MDR.
REQ-007 Port selMDR, input, 1: MDR source select; 1 = memory read at MAR, 0 = bus.
REQ-008 Port memWE, input, 1: write MDR to address MAR.
REQ-009 Port mdrOut, output, 16: current MDR, driven onto the bus by the datapath when enaMDR is high.
REQ-010 Port kbdValid, input, 1: keyboard character offered.
REQ-011 Port kbdData, input, 16: keyboard character.
REQ-012 Port kbdReady, output, 1: keyboard data register empty.
REQ-013 Port dispValid, output, 1: display character pending.
REQ-014 Port dispData, output, 16: display character.
REQ-015 Port dispReady, input, 1: display consumer accepts the character.
REQ-016 Port dispOverrun, output, 1: sticky flag; a DDR write was dropped.

Function
REQ-017 MAR and MDR SHALL each be 16-bit registers.
REQ-018 mdrOut SHALL equal MDR combinationally.
REQ-019 With ldMAR high, MAR SHALL take bus at the next edge.
REQ-020 With ldMDR high and selMDR=0, MDR SHALL take bus at the next edge.
REQ-021 With ldMDR high and selMDR=1, MDR SHALL take the read value at the pre-edge MAR at the next edge, giving one-cycle read latency with data valid in the following cycle.
REQ-022 With memWE high, the pre-edge MDR SHALL be written to the pre-edge MAR at the edge.
REQ-023 In simultaneous ldMAR/ldMDR/memWE, writes and reads SHALL use the old MAR/MDR.
REQ-024 A read of an address written in the same cycle SHALL return the old contents.
REQ-025 The address map SHALL be: RAM 0x0000..RAM_WORDS-1; KBSR 0xFE00; KBDR 0xFE02; DSR 0xFE04; DDR 0xFE06.
REQ-026 Reads of any other address SHALL return 0x0000, and writes to it SHALL be ignored.
REQ-027 A KBSR read SHALL return {kbdFull,15'b0}.
REQ-028 A KBDR read SHALL return the held character and clear kbdFull at the same edge.
REQ-029 kbdReady SHALL be the inverse of kbdFull.
REQ-030 When kbdValid and kbdReady are both high, the block SHALL capture kbdData and set kbdFull at the edge.
REQ-031 No new capture SHALL occur in the cycle in which a KBDR read clears kbdFull; kbdReady rises the following cycle.
REQ-032 A DSR read SHALL return {~dispValid,15'b0}.
REQ-033 A memWE write to DDR with dispValid=0 SHALL load dispData <= MDR and set dispValid at the edge.
REQ-034 A dispValid&&dispReady edge SHALL complete the transfer and clear dispValid.
REQ-035 A DDR write in the same cycle as a completing transfer SHALL load the new data and keep dispValid=1.
REQ-036 A DDR write while dispValid=1 with no transfer completing SHALL be dropped and set dispOverrun.
REQ-037 dispData SHALL remain stable while dispValid=1.
REQ-038 Writes to KBSR, KBDR and DSR SHALL be ignored.

Reset
REQ-039 Reset SHALL clear MAR, MDR and dispData to 0x0000, and clear kbdFull, dispValid and dispOverrun to 0, making kbdReady 1.
REQ-040 RAM contents SHALL be unaffected by reset.
REQ-041 Reset SHALL take priority over every load, write and handshake in the same cycle; a pending display character is discarded.

Structure
REQ-042 The MMIO address constants (ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR) SHALL live in package lc3.
REQ-043 The RAM SHALL be a sub-module memory_ram: single-port, RAM_WORDS x 16, synchronous write, read data registered into MDR by memory_unit.

Verification
REQ-044 Scenario: bus=0x0010 with ldMAR, then MDR=0xBEEF and memWE, then ldMDR with selMDR=1 -> mdrOut=0xBEEF one cycle after the load.
REQ-045 Scenario: same cycle ldMAR(bus=0x0020), ldMDR(bus), memWE with old MAR=0x0010 and old MDR=0x1111 -> mem[0x0010]=0x1111 and mem[0x0020] unchanged.
REQ-046 Scenario: kbdValid with kbdData=0x0041 -> kbdReady=0 and a KBSR read gives 0x8000; a KBDR read gives 0x0041, then kbdReady=1 the next cycle.
REQ-047 Scenario: a DDR write of 0x0048 with dispReady=0 -> dispValid=1; a second DDR write of 0x0049 is dropped and dispOverrun=1; then dispReady=1 -> dispValid=0.
REQ-048 Scenario: a DDR write in the same cycle as a dispReady handshake -> dispData holds the new value and dispValid stays 1.
REQ-049 Scenario: reset asserted with dispValid=1 and kbdFull=1 -> the next cycle shows dispValid=0, kbdReady=1, mdrOut=0x0000, and RAM contents intact.
